// File: rtl/mux_sel_sequencer_pkg.sv
// Shared types and helpers for the mux select sequencer.
// State encoding and round-robin pick function.
package mux_sel_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        GUARD  = 2'd3
    } state_t;

    // Both requesting: pick the channel not served last.
    // Otherwise the single requester (caller checks any).
    function automatic logic rr_pick(
        input logic req0,
        input logic req1,
        input logic last
    );
        if (req0 && req1) begin
            return ~last;
        end
        return req1;
    endfunction

endpackage

// File: rtl/mux_sel_hold_cnt.sv
// Dwell down-counter for the mux select sequencer.
// Load has priority over decrement; saturates at zero.
module mux_sel_hold_cnt #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    // Count register: reload on grant, step down while dwelling.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign count = cnt_q;
    assign zero  = (cnt_q == '0);

endmodule

// File: rtl/mux_sel_sequencer.sv
// Round-robin select sequencer for a 2:1 mux with fixed grant dwell.
// Optional guard cycle between channel switches: MUX_SEL_SEQUENCER_GUARD_EN.
module mux_sel_sequencer
    import mux_sel_sequencer_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    localparam int CNT_W = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    output logic             s,
    output logic             gnt0,
    output logic             gnt1,
    output logic             valid,
    output logic [CNT_W-1:0] cnt
);

    if (HOLD_CYCLES < 1) begin : g_hold_chk
        $error("HOLD_CYCLES must be >= 1");
    end

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   s_q, s_d;
    logic   gnt0_q, gnt0_d;
    logic   gnt1_q, gnt1_d;
    logic   valid_q, valid_d;

    logic             cnt_load;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_val;
    logic [CNT_W-1:0] cnt_cur;
    logic             cnt_zero;

    logic grant_en;
    logic grant_ch;
    logic idle_en;
    logic switch_en;
    logic cur;
    logic own;
    logic oth;

`ifdef MUX_SEL_SEQUENCER_GUARD_EN
    logic pend_q, pend_d;
`endif

    mux_sel_hold_cnt #(
        .CNT_W(CNT_W)
    ) u_hold_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (cnt_load),
        .dec     (cnt_dec),
        .load_val(cnt_val),
        .count   (cnt_cur),
        .zero    (cnt_zero)
    );

    // Arbitration decision and next-state for the grant FSM.
    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        s_d       = s_q;
        gnt0_d    = gnt0_q;
        gnt1_d    = gnt1_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        cnt_val   = RELOAD;
        grant_en  = 1'b0;
        grant_ch  = 1'b0;
        idle_en   = 1'b0;
        switch_en = 1'b0;
        cur       = (state_q == GRANT1);
        own       = cur ? req1 : req0;
        oth       = cur ? req0 : req1;
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
        pend_d    = pend_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_en = 1'b1;
                    grant_ch = rr_pick(req0, req1, last_q);
                end
            end
            GRANT0, GRANT1: begin
                if (!own) begin
                    if (oth) begin
                        switch_en = 1'b1;
                    end else begin
                        idle_en = 1'b1;
                    end
                end else if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (oth) begin
                    switch_en = 1'b1;
                end else begin
                    grant_en = 1'b1;
                    grant_ch = cur;
                end
            end
            GUARD: begin
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
                if (pend_q ? req1 : req0) begin
                    grant_en = 1'b1;
                    grant_ch = pend_q;
                end else if (pend_q ? req0 : req1) begin
                    grant_en = 1'b1;
                    grant_ch = ~pend_q;
                end else begin
                    idle_en = 1'b1;
                end
`else
                idle_en = 1'b1;
`endif
            end
        endcase

        if (switch_en) begin
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
            state_d  = GUARD;
            pend_d   = ~cur;
            gnt0_d   = 1'b0;
            gnt1_d   = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = '0;
`else
            grant_en = 1'b1;
            grant_ch = ~cur;
`endif
        end

        if (grant_en) begin
            state_d  = grant_ch ? GRANT1 : GRANT0;
            gnt0_d   = ~grant_ch;
            gnt1_d   = grant_ch;
            s_d      = grant_ch;
            last_d   = grant_ch;
            cnt_load = 1'b1;
            cnt_val  = RELOAD;
        end

        if (idle_en) begin
            state_d  = IDLE;
            gnt0_d   = 1'b0;
            gnt1_d   = 1'b0;
            cnt_load = 1'b1;
            cnt_val  = '0;
        end

        valid_d = gnt0_d | gnt1_d;
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            s_q     <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            valid_q <= 1'b0;
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
            pend_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            s_q     <= s_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            valid_q <= valid_d;
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
            pend_q  <= pend_d;
`endif
        end
    end

    assign s     = s_q;
    assign gnt0  = gnt0_q;
    assign gnt1  = gnt1_q;
    assign valid = valid_q;
    assign cnt   = cnt_cur;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Scoreboard bench for mux_sel_sequencer.
// DUT a: HOLD_CYCLES=4, DUT b: HOLD_CYCLES=1.
module tb_mux_sel_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       a_rst_n = 1'b0, a_req0 = 1'b0, a_req1 = 1'b0;
    logic       a_s, a_g0, a_g1, a_v;
    logic [2:0] a_cnt;
    logic       b_rst_n = 1'b0, b_req0 = 1'b0, b_req1 = 1'b0;
    logic       b_s, b_g0, b_g1, b_v;
    logic [0:0] b_cnt;

    mux_sel_sequencer #(.HOLD_CYCLES(4)) u_a (
        .clk(clk), .rst_n(a_rst_n), .req0(a_req0), .req1(a_req1),
        .s(a_s), .gnt0(a_g0), .gnt1(a_g1), .valid(a_v), .cnt(a_cnt)
    );

    mux_sel_sequencer #(.HOLD_CYCLES(1)) u_b (
        .clk(clk), .rst_n(b_rst_n), .req0(b_req0), .req1(b_req1),
        .s(b_s), .gnt0(b_g0), .gnt1(b_g1), .valid(b_v), .cnt(b_cnt)
    );

    typedef struct {
        int         dut;
        logic [3:0] o;
        int         cnt;
        string      nm;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // in = {rst_n, req0, req1}; o = {s, gnt0, gnt1, valid}
    task automatic step(input int dut, input logic [2:0] in,
                        input logic [3:0] o, input int c, input string nm);
        exp_t e;
        @(negedge clk);
        if (dut == 0) begin
            a_rst_n = in[2]; a_req0 = in[1]; a_req1 = in[0];
        end else begin
            b_rst_n = in[2]; b_req0 = in[1]; b_req1 = in[0];
        end
        e.dut = dut; e.o = o; e.cnt = c; e.nm = nm;
        sbq.push_back(e);
    endtask

    // Monitor: pop one expectation per edge and compare.
    initial begin
        exp_t       e;
        logic [3:0] got;
        int         gc;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.dut == 0) begin
                    got = {a_s, a_g0, a_g1, a_v}; gc = int'(a_cnt);
                end else begin
                    got = {b_s, b_g0, b_g1, b_v}; gc = int'(b_cnt);
                end
                checks++;
                if (got !== e.o || gc != e.cnt) begin
                    errors++;
                    $display("FAIL %s: got s/g0/g1/v=%b cnt=%0d want %b cnt=%0d",
                             e.nm, got, gc, e.o, e.cnt);
                end
            end
            checks++;
            if ((a_v !== (a_g0 | a_g1)) || (a_g0 & a_g1) ||
                (b_v !== (b_g0 | b_g1)) || (b_g0 & b_g1)) begin
                errors++;
                $display("FAIL invariant: a g0/g1/v=%b%b%b b=%b%b%b want excl",
                         a_g0, a_g1, a_v, b_g0, b_g1, b_v);
            end
        end
    end

    initial begin
        // reset held with both requests
        step(0, 3'b011, 4'b0000, 0, "rst_a");
        step(0, 3'b011, 4'b0000, 0, "rst_b");
        // req0 alone: continuous dwell with reload
        step(0, 3'b110, 4'b0101, 3, "r0_c3");
        step(0, 3'b110, 4'b0101, 2, "r0_c2");
        step(0, 3'b110, 4'b0101, 1, "r0_c1");
        step(0, 3'b110, 4'b0101, 0, "r0_c0");
        step(0, 3'b110, 4'b0101, 3, "r0_reload");
        step(0, 3'b110, 4'b0101, 2, "r0_c2b");
        step(0, 3'b100, 4'b0000, 0, "r0_release");
        // both from reset: round-robin alternation
        step(0, 3'b000, 4'b0000, 0, "rst3");
        step(0, 3'b111, 4'b0101, 3, "rr_g0_3");
        step(0, 3'b111, 4'b0101, 2, "rr_g0_2");
        step(0, 3'b111, 4'b0101, 1, "rr_g0_1");
        step(0, 3'b111, 4'b0101, 0, "rr_g0_0");
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
        step(0, 3'b111, 4'b0000, 0, "rr_guard0");
`endif
        step(0, 3'b111, 4'b1011, 3, "rr_g1_3");
        step(0, 3'b111, 4'b1011, 2, "rr_g1_2");
        step(0, 3'b111, 4'b1011, 1, "rr_g1_1");
        step(0, 3'b111, 4'b1011, 0, "rr_g1_0");
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
        step(0, 3'b111, 4'b1000, 0, "rr_guard1");
`endif
        step(0, 3'b111, 4'b0101, 3, "rr_g0_again");
        // req1 alone, dropped at cnt=2
        step(0, 3'b000, 4'b0000, 0, "rst4");
        step(0, 3'b101, 4'b1011, 3, "r1_c3");
        step(0, 3'b101, 4'b1011, 2, "r1_c2");
        step(0, 3'b100, 4'b1000, 0, "r1_drop");
        step(0, 3'b100, 4'b1000, 0, "idle_s_hold");
        // reset mid-grant, then gnt0 wins the tie
        step(0, 3'b101, 4'b1011, 3, "g1_c3");
        step(0, 3'b101, 4'b1011, 2, "g1_c2");
        step(0, 3'b101, 4'b1011, 1, "g1_c1");
        step(0, 3'b011, 4'b0000, 0, "rst_mid");
        step(0, 3'b111, 4'b0101, 3, "post_rst_g0");
        // early release with other requester waiting
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
        step(0, 3'b101, 4'b0000, 0, "early_guard");
`endif
        step(0, 3'b101, 4'b1011, 3, "early_sw");
        step(0, 3'b100, 4'b1000, 0, "early_idle");
        // HOLD_CYCLES=1 alternation
        step(1, 3'b011, 4'b0000, 0, "b_rst");
        step(1, 3'b111, 4'b0101, 0, "b_g0");
`ifdef MUX_SEL_SEQUENCER_GUARD_EN
        step(1, 3'b111, 4'b0000, 0, "b_guard0");
        step(1, 3'b111, 4'b1011, 0, "b_g1");
        step(1, 3'b111, 4'b1000, 0, "b_guard1");
        step(1, 3'b111, 4'b0101, 0, "b_g0b");
`else
        step(1, 3'b111, 4'b1011, 0, "b_g1");
        step(1, 3'b111, 4'b0101, 0, "b_g0b");
        step(1, 3'b111, 4'b1011, 0, "b_g1b");
`endif
        repeat (4) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
